// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
// Contents: sequencer state enum, default counter/address widths, minimum
// legal frame dimension and a helper that validates frame dimensions.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int COL_W_DEF  = 10;
    localparam int ROW_W_DEF  = 10;
    localparam int ADDR_W_DEF = 20;
    localparam int MIN_DIM    = 3;

    // A 3x3 window needs at least three rows and three columns.
    function automatic logic dims_ok(input int w, input int h);
        return (w >= MIN_DIM) && (h >= MIN_DIM);
    endfunction

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// Pixel read bus between the frame sequencer and the input memory / line buffer.
//   rd_req  : sequencer -> memory, pixel read request (held until rd_ack)
//   rd_addr : sequencer -> memory, linear row-major pixel address
//   rd_ack  : memory -> sequencer, request accepted, pixel valid this cycle
//   lb_push : sequencer -> line buffer, write strobe (rd_req & rd_ack)
// master modport: sequencer side. slave modport: memory / line-buffer side.
interface sobel_frame_sequencer_if #(
    parameter int ADDR_W = sobel_pkg::ADDR_W_DEF
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              lb_push;

    modport master (output rd_req, output rd_addr, output lb_push, input rd_ack);
    modport slave  (input rd_req, input rd_addr, input lb_push, output rd_ack);
endinterface

// File: rtl/sobel_frame_sequencer_pixel_pos_counter.sv
// Row/column position counter for the pixel currently being requested.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : restart at (0,0) for a new frame
//   inc          : advance one pixel; column wraps at width-1 and row advances
//   width/height : frame dimensions (held stable during a frame)
//   row/col      : current position
//   col_last     : current column is the last one of the row
//   frame_last   : current pixel is the last pixel of the frame
module pixel_pos_counter #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [COL_W-1:0] width,
    input  logic [ROW_W-1:0] height,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             col_last,
    output logic             frame_last
);
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_last;

    assign col_last   = (col_q == width - COL_W'(1));
    assign row_last   = (row_q == height - ROW_W'(1));
    assign frame_last = col_last & row_last;
    assign row        = row_q;
    assign col        = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: fetches one frame pixel-by-pixel from input memory,
// pushes each pixel into the 3-line buffer, flags every complete interior 3x3
// window with its centre position and output address, and signals frame end.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   start, abort            : frame start pulse (IDLE only) / cancel frame
//   img_width, img_height   : frame dims, sampled when start is accepted
//   rd_bus (master)         : rd_req/rd_addr/rd_ack/lb_push pixel read bus
//   buffer_full             : >= 2*W+3 pixels pushed this frame, sticky to frame end
//   win_valid/out_row/out_col/wr_addr : interior window centre, 1 cycle after ack
//   busy                    : high while fetching
//   frame_done              : 1-cycle pulse together with the last window
//   cfg_err                 : sticky, start with W<3 or H<3
//   stall_cnt (optional)    : FETCH cycles with rd_req & !rd_ack, saturating
// Optional feature macro: SOBEL_STALL_CNT_EN (adds stall_cnt port and counter).
module sobel_frame_sequencer
    import sobel_pkg::*;
#(
    parameter int COL_W  = COL_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [COL_W-1:0]        img_width,
    input  logic [ROW_W-1:0]        img_height,
    sobel_frame_sequencer_if.master rd_bus,
    output logic                    buffer_full,
    output logic                    win_valid,
    output logic [ROW_W-1:0]        out_row,
    output logic [COL_W-1:0]        out_col,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err
`ifdef SOBEL_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);
    seq_state_t        state_q, state_d;
    logic [COL_W-1:0]  w_q, w_d;
    logic [ROW_W-1:0]  h_q, h_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              buffer_full_q, buffer_full_d;
    logic              win_valid_q, win_valid_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic [COL_W-1:0]  out_col_q, out_col_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              push;
    logic              accept_start;
    logic [ROW_W-1:0]  pos_row;
    logic [COL_W-1:0]  pos_col;
    logic              pos_col_last;
    logic              pos_frame_last;
    logic [ADDR_W-1:0] bf_thresh;

    assign push         = rd_req_q & rd_bus.rd_ack;
    assign accept_start = (state_q == IDLE) & start;

    // Ack number 2*W+3 (1-based) is the push made while rd_addr == 2*W+2.
    assign bf_thresh = ADDR_W'({w_q, 1'b0}) + ADDR_W'(2);

    pixel_pos_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept_start),
        .inc        (push),
        .width      (w_q),
        .height     (h_q),
        .row        (pos_row),
        .col        (pos_col),
        .col_last   (pos_col_last),
        .frame_last (pos_frame_last)
    );

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        h_d           = h_q;
        rd_req_d      = rd_req_q;
        rd_addr_d     = rd_addr_q;
        buffer_full_d = buffer_full_q;
        win_valid_d   = 1'b0;
        out_row_d     = out_row_q;
        out_col_d     = out_col_q;
        wr_addr_d     = wr_addr_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        cfg_err_d     = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok(32'(img_width), 32'(img_height))) begin
                        state_d       = FETCH;
                        w_d           = img_width;
                        h_d           = img_height;
                        rd_req_d      = 1'b1;
                        busy_d        = 1'b1;
                        rd_addr_d     = '0;
                        buffer_full_d = 1'b0;
                        cfg_err_d     = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            FETCH: begin
                // Abort discards the frame, including a pixel acked in the same cycle.
                if (abort) begin
                    state_d       = IDLE;
                    rd_req_d      = 1'b0;
                    busy_d        = 1'b0;
                    buffer_full_d = 1'b0;
                end else if (push) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == bf_thresh) begin
                        buffer_full_d = 1'b1;
                    end
                    // Pixel (r,c) completes the window centred one row up, one column left.
                    if (pos_row >= ROW_W'(2) && pos_col >= COL_W'(2)) begin
                        win_valid_d = 1'b1;
                        out_row_d   = pos_row - ROW_W'(1);
                        out_col_d   = pos_col - COL_W'(1);
                        wr_addr_d   = rd_addr_q - ADDR_W'(w_q) - ADDR_W'(1);
                    end
                    if (pos_frame_last) begin
                        state_d      = DONE;
                        rd_req_d     = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d       = IDLE;
                buffer_full_d = 1'b0;
            end

            default: begin
                state_d  = IDLE;
                rd_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            w_q           <= '0;
            h_q           <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            buffer_full_q <= 1'b0;
            win_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            wr_addr_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            h_q           <= h_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            buffer_full_q <= buffer_full_d;
            win_valid_q   <= win_valid_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
            wr_addr_q     <= wr_addr_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign rd_bus.rd_req  = rd_req_q;
    assign rd_bus.rd_addr = rd_addr_q;
    assign rd_bus.lb_push = push;
    assign buffer_full    = buffer_full_q;
    assign win_valid      = win_valid_q;
    assign out_row        = out_row_q;
    assign out_col        = out_col_q;
    assign wr_addr        = wr_addr_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign cfg_err        = cfg_err_q;

`ifdef SOBEL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept_start) begin
            stall_cnt_d = '0;
        end else if (state_q == FETCH && rd_req_q && !rd_bus.rd_ack && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
